udp_tx: RTL

- UDP transmit framer; the transmit counterpart of the UDP receive path out of the frame splitter.
- Accepts a send request (dst IP, dst port, payload length) plus an 8-bit payload stream.
- Resolves the dst MAC through the ARP cache query port, then emits Ethernet + IPv4 + UDP header (42 bytes) followed by payload on the net tx byte stream toward the tx arbiter/MAC.
- MAC appends padding and FCS.

---
 rtl/net_pkg.sv | 52 +++++
 rtl/ip_hdr_csum.sv | 41 ++++
 rtl/udp_tx.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/net_pkg.sv
// Shared constants, header layout and state encoding for the UDP transmit framer.
// The one's-complement fold helper is shared by anything computing IPv4 header checksums.
package net_pkg;

   localparam logic [15:0] ETH_TYPE_IPV4   = 16'h0800;
   localparam logic [7:0]  IP_PROTO_UDP    = 8'h11;
   localparam int          HDR_LEN         = 42;
   localparam logic [15:0] UDP_MAX_PAYLOAD = 16'd1472;
   localparam logic [47:0] BCAST_MAC       = 48'hFFFF_FFFF_FFFF;
   localparam logic [31:0] BCAST_IP        = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      IDLE,
      ARP_REQ,
      ARP_WAIT,
      CSUM,
      HEADER,
      PAYLOAD,
      PAD,
      DROP
   } udp_tx_state_t;

   // Field order is wire order: the first byte on the wire is the top byte of the struct.
   typedef struct packed {
      logic [47:0] dst_mac;
      logic [47:0] src_mac;
      logic [15:0] eth_type;
      logic [7:0]  ver_ihl;
      logic [7:0]  tos;
      logic [15:0] total_len;
      logic [15:0] id;
      logic [15:0] flags_frag;
      logic [7:0]  ttl;
      logic [7:0]  proto;
      logic [15:0] hdr_csum;
      logic [31:0] src_ip;
      logic [31:0] dst_ip;
      logic [15:0] src_port;
      logic [15:0] dst_port;
      logic [15:0] udp_len;
      logic [15:0] udp_csum;
   } hdr_t;

   function automatic logic [15:0] csum_fold(input logic [19:0] sum);
      logic [16:0] f1;
      logic [16:0] f2;
      f1 = {1'b0, sum[15:0]} + {13'd0, sum[19:16]};
      f2 = {1'b0, f1[15:0]} + {16'd0, f1[16]};
      return f2[15:0];
   endfunction

endpackage

// File: rtl/ip_hdr_csum.sv
// IPv4 header checksum, two cycles: start registers the raw 20-bit sum, and the next
// cycle presents the folded, inverted checksum together with done. No backpressure.
module ip_hdr_csum
   import net_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] total_len,
   input  logic [15:0] id,
   input  logic [7:0]  ttl,
   input  logic [31:0] src_ip,
   input  logic [31:0] dst_ip,
   output logic [15:0] csum,
   output logic        done
);

   logic [19:0] sum_c;
   logic [19:0] sum_q;
   logic        done_q;

   // Checksum field counts as zero, so only nine words contribute.
   assign sum_c = 20'h04500 + {4'h0, total_len} + {4'h0, id} + 20'h04000
                + {4'h0, ttl, IP_PROTO_UDP}
                + {4'h0, src_ip[31:16]} + {4'h0, src_ip[15:0]}
                + {4'h0, dst_ip[31:16]} + {4'h0, dst_ip[15:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q  <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= start;
         if (start) sum_q <= sum_c;
      end
   end

   assign csum = ~csum_fold(sum_q);
   assign done = done_q;

endmodule

// File: rtl/udp_tx.sv
// UDP transmit framer: ARP lookup, then a 42-byte Eth/IPv4/UDP header and the payload (pad or trim to len).
// Payload passes through with zero latency; stalls follow net_tready_in. UDP_BCAST_EN: broadcast IP skips ARP.
module udp_tx
   import net_pkg::*;
#(
   parameter logic [31:0] LOCAL_IP   = 32'hC0A8_006E,
   parameter logic [47:0] LOCAL_MAC  = 48'hABCD_1234_5678,
   parameter logic [15:0] LOCAL_PORT = 16'd8080,
   parameter logic [7:0]  IP_TTL     = 8'd64
) (
   input  logic        logic_clk,
   input  logic        logic_rst,
   input  logic [31:0] udp_treq_ip_in,
   input  logic [15:0] udp_treq_port_in,
   input  logic [15:0] udp_treq_len_in,
   input  logic        udp_treq_valid_in,
   output logic        udp_treq_ready_out,
   input  logic [7:0]  udp_tdata_in,
   input  logic        udp_tvalid_in,
   output logic        udp_tready_out,
   input  logic        udp_tlast_in,
   output logic [31:0] arp_query_ip_out,
   output logic        arp_query_valid_out,
   input  logic        arp_query_ready_in,
   input  logic [47:0] arp_response_mac_in,
   input  logic        arp_response_valid_in,
   output logic        arp_response_ready_out,
   input  logic        arp_response_err_in,
   output logic [7:0]  net_tdata_out,
   output logic        net_tvalid_out,
   input  logic        net_tready_in,
   output logic        net_tlast_out,
   output logic        udp_terr_out
);

   udp_tx_state_t state_q, state_d;

   logic [31:0] ip_q;
   logic [15:0] port_q;
   logic [15:0] len_q;
   logic [47:0] mac_q;
   logic [15:0] id_q;
   logic [15:0] csum_q;
   logic [5:0]  hdr_cnt_q;
   logic [15:0] pay_cnt_q;
   logic        terr_q;
   logic        armed_q;

   logic        req_take, mac_take, csum_take, hdr_adv, pay_adv, frame_done, terr_set;
   logic        csum_start, csum_done;
   logic [15:0] csum;
   logic [15:0] total_len, udp_len;
   logic        len_bad, pay_last;
   hdr_t        hdr;
   logic [HDR_LEN-1:0][7:0] hdr_bytes;

   assign total_len = len_q + 16'd28;
   assign udp_len   = len_q + 16'd8;
   assign len_bad   = (udp_treq_len_in == 16'd0) || (udp_treq_len_in > UDP_MAX_PAYLOAD);
   assign pay_last  = (pay_cnt_q == len_q - 16'd1);

   ip_hdr_csum u_csum (
      .clk       (logic_clk),
      .rst       (logic_rst),
      .start     (csum_start),
      .total_len (total_len),
      .id        (id_q),
      .ttl       (IP_TTL),
      .src_ip    (LOCAL_IP),
      .dst_ip    (ip_q),
      .csum      (csum),
      .done      (csum_done)
   );

   always_comb begin
      hdr            = '0;
      hdr.dst_mac    = mac_q;
      hdr.src_mac    = LOCAL_MAC;
      hdr.eth_type   = ETH_TYPE_IPV4;
      hdr.ver_ihl    = 8'h45;
      hdr.tos        = 8'h00;
      hdr.total_len  = total_len;
      hdr.id         = id_q;
      hdr.flags_frag = 16'h4000;
      hdr.ttl        = IP_TTL;
      hdr.proto      = IP_PROTO_UDP;
      hdr.hdr_csum   = csum_q;
      hdr.src_ip     = LOCAL_IP;
      hdr.dst_ip     = ip_q;
      hdr.src_port   = LOCAL_PORT;
      hdr.dst_port   = port_q;
      hdr.udp_len    = udp_len;
      hdr.udp_csum   = 16'h0000;
   end

   assign hdr_bytes        = hdr;
   assign arp_query_ip_out = ip_q;
   assign udp_terr_out     = terr_q;

   always_ff @(posedge logic_clk or posedge logic_rst) begin
      if (logic_rst) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d                = state_q;
      udp_treq_ready_out     = 1'b0;
      udp_tready_out         = 1'b0;
      arp_query_valid_out    = 1'b0;
      arp_response_ready_out = 1'b0;
      net_tdata_out          = 8'h00;
      net_tvalid_out         = 1'b0;
      net_tlast_out          = 1'b0;
      req_take               = 1'b0;
      mac_take               = 1'b0;
      csum_take              = 1'b0;
      csum_start             = 1'b0;
      hdr_adv                = 1'b0;
      pay_adv                = 1'b0;
      frame_done             = 1'b0;
      terr_set               = 1'b0;
      case (state_q)
         IDLE: begin
            // armed_q keeps the request port closed while reset is (or was just) asserted.
            udp_treq_ready_out = armed_q;
            if (udp_treq_valid_in && armed_q) begin
               req_take = 1'b1;
               if (len_bad) begin
                  state_d  = DROP;
                  terr_set = 1'b1;
               end
`ifdef UDP_BCAST_EN
               else if (udp_treq_ip_in == BCAST_IP) state_d = CSUM;
`endif
               else state_d = ARP_REQ;
            end
         end
         ARP_REQ: begin
            arp_query_valid_out = 1'b1;
            if (arp_query_ready_in) state_d = ARP_WAIT;
         end
         ARP_WAIT: begin
            arp_response_ready_out = 1'b1;
            if (arp_response_valid_in) begin
               if (arp_response_err_in) begin
                  state_d  = DROP;
                  terr_set = 1'b1;
               end else begin
                  mac_take = 1'b1;
                  state_d  = CSUM;
               end
            end
         end
         CSUM: begin
            csum_start = !csum_done;
            if (csum_done) begin
               csum_take = 1'b1;
               state_d   = HEADER;
            end
         end
         HEADER: begin
            net_tvalid_out = 1'b1;
            net_tdata_out  = hdr_bytes[6'(HDR_LEN - 1) - hdr_cnt_q];
            if (net_tready_in) begin
               hdr_adv = 1'b1;
               if (hdr_cnt_q == 6'(HDR_LEN - 1)) state_d = PAYLOAD;
            end
         end
         PAYLOAD: begin
            net_tvalid_out = udp_tvalid_in;
            net_tdata_out  = udp_tdata_in;
            net_tlast_out  = pay_last;
            udp_tready_out = net_tready_in;
            if (udp_tvalid_in && net_tready_in) begin
               pay_adv = 1'b1;
               if (pay_last) begin
                  frame_done = 1'b1;
                  state_d    = udp_tlast_in ? IDLE : DROP;
               end else if (udp_tlast_in) begin
                  state_d = PAD;
               end
            end
         end
         PAD: begin
            net_tvalid_out = 1'b1;
            net_tlast_out  = pay_last;
            if (net_tready_in) begin
               pay_adv = 1'b1;
               if (pay_last) begin
                  frame_done = 1'b1;
                  state_d    = IDLE;
               end
            end
         end
         DROP: begin
            udp_tready_out = 1'b1;
            if (udp_tvalid_in && udp_tlast_in) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge logic_clk or posedge logic_rst) begin
      if (logic_rst) begin
         ip_q      <= '0;
         port_q    <= '0;
         len_q     <= '0;
         mac_q     <= '0;
         id_q      <= '0;
         csum_q    <= '0;
         hdr_cnt_q <= '0;
         pay_cnt_q <= '0;
         terr_q    <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         armed_q <= 1'b1;
         terr_q  <= terr_set;
         // Broadcast MAC is the default; an ARP answer overwrites it.
         if (req_take) begin
            ip_q      <= udp_treq_ip_in;
            port_q    <= udp_treq_port_in;
            len_q     <= udp_treq_len_in;
            mac_q     <= BCAST_MAC;
            hdr_cnt_q <= '0;
            pay_cnt_q <= '0;
         end
         if (mac_take)   mac_q     <= arp_response_mac_in;
         if (csum_take)  csum_q    <= csum;
         if (hdr_adv)    hdr_cnt_q <= hdr_cnt_q + 6'd1;
         if (pay_adv)    pay_cnt_q <= pay_cnt_q + 16'd1;
         if (frame_done) id_q      <= id_q + 16'd1;
      end
   end

endmodule
